// File: rtl/pair_sequencer.sv
// pair_sequencer: upstream feeder for find_MAX.
// Buffers (A, B, instruction) pairs from a valid/ready producer in a small
// FIFO, then issues them to find_MAX in groups of PAIRS_PER_OP using the
// start / valid / one_left protocol. Waits for finish, captures maximum as a
// one-cycle result pulse, and aborts with timeout_err if finish never comes
// (or never drops).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           producer handshake (in_ready = count < FIFO_DEPTH)
//   in_a, in_b, in_instr        pushed pair
//   start, valid, one_left      find_MAX control (mutually exclusive)
//   Data_A, Data_B, instruction find_MAX data, zero whenever valid = 0
//   finish, maximum             find_MAX completion and answer
//   result_valid, result        one-cycle capture pulse, held result
//   timeout_err                 one-cycle abort pulse
//   busy                        state != IDLE
module pair_sequencer #(
  parameter int PAIRS_PER_OP = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int GAP          = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [2:0] in_instr,
  output logic       start,
  output logic       valid,
  output logic [7:0] Data_A,
  output logic [7:0] Data_B,
  output logic [2:0] instruction,
  output logic       one_left,
  input  logic       finish,
  input  logic [7:0] maximum,
  output logic       result_valid,
  output logic [7:0] result,
  output logic       timeout_err,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = (PAIRS_PER_OP > 1) ? $clog2(PAIRS_PER_OP) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GAP, S_SEND, S_ONE_LEFT, S_SEND_LAST, S_WAIT_FIN, S_DRAIN
  } state_t;

  state_t        state, state_n;
  logic [18:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [KW-1:0] k;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] tcnt;
  logic [18:0]   head;
  logic          push, pop, cap, to_fire;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (count < CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = valid;
  assign head     = mem[rd_ptr];

  assign start       = (state == S_START);
  assign one_left    = (state == S_ONE_LEFT);
  assign valid       = (state == S_SEND) || (state == S_SEND_LAST);
  assign busy        = (state != S_IDLE);
  assign instruction = valid ? head[18:16] : '0;
  assign Data_A      = valid ? head[15:8]  : '0;
  assign Data_B      = valid ? head[7:0]   : '0;

  // Storage needs no reset: nothing is read unless count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_instr, in_a, in_b};
  end

  always_comb begin
    state_n = state;
    cap     = 1'b0;
    to_fire = 1'b0;
    case (state)
      S_IDLE:      if (count >= CW'(PAIRS_PER_OP)) state_n = S_START;
      S_START:     state_n = S_GAP;
      S_GAP:       if (gcnt == GW'(GAP - 1))
                     state_n = (k < KW'(PAIRS_PER_OP - 1)) ? S_SEND : S_ONE_LEFT;
      S_SEND:      state_n = S_GAP;
      S_ONE_LEFT:  state_n = S_SEND_LAST;
      S_SEND_LAST: state_n = S_WAIT_FIN;
      // finish wins over an expiring timer so a late answer is still used
      S_WAIT_FIN: begin
        if (finish) begin
          cap     = 1'b1;
          state_n = S_DRAIN;
        end else if (tcnt >= TW'(TIMEOUT - 1)) begin
          to_fire = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!finish) begin
          state_n = S_IDLE;
        end else if (tcnt >= TW'(TIMEOUT - 1)) begin
          to_fire = 1'b1;
          state_n = S_IDLE;
        end
      end
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      k            <= '0;
      gcnt         <= '0;
      tcnt         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (state == S_START)     k <= '0;
      else if (state == S_SEND) k <= k + 1'b1;
      // counters restart whenever their state is not active, so entry sees 0
      gcnt <= (state == S_GAP) ? gcnt + 1'b1 : '0;
      tcnt <= (state == S_WAIT_FIN || state == S_DRAIN) ? tcnt + 1'b1 : '0;
      result_valid <= cap;
      timeout_err  <= to_fire;
      if (cap) result <= maximum;
    end
  end

endmodule

// File: tb/tb_pair_sequencer.sv
// Directed bench for pair_sequencer: cycle-exact schedule, FIFO ordering,
// full/backpressure, no partial operations, DRAIN hold-off, timeout, reset.
module tb_pair_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_instr;
  logic       start, valid, one_left, finish;
  logic [7:0] Data_A, Data_B, maximum, result;
  logic [2:0] instruction;
  logic       result_valid, timeout_err, busy;

  pair_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_instr(in_instr),
    .start(start), .valid(valid), .Data_A(Data_A), .Data_B(Data_B),
    .instruction(instruction), .one_left(one_left),
    .finish(finish), .maximum(maximum),
    .result_valid(result_valid), .result(result),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int n_start = 0, n_rv = 0, n_to = 0;
  logic [18:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // find_MAX stand-in: finish rises 3 cycles after the last valid, held fin_hold cycles
  logic       fin_en;
  int         fin_hold;
  logic [7:0] fin_max;
  int         cd = 0, hold = 0;
  logic       ol_seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cd = 0; hold = 0; ol_seen = 1'b0; finish = 1'b0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) hold = fin_hold;
      end
      finish = fin_en && (hold > 0);
      if (hold > 0) hold--;
      if (one_left) ol_seen = 1'b1;
      if (valid && ol_seen) begin ol_seen = 1'b0; cd = 3; end
    end
    maximum = fin_max;
  end

  // monitor: event counts, exclusivity, issued data against push order
  always @(negedge clk) begin
    logic [18:0] e;
    logic        viol;
    if (start) n_start++;
    if (result_valid) n_rv++;
    if (timeout_err) n_to++;
    viol = (int'(start) + int'(valid) + int'(one_left) > 1) || (result_valid && timeout_err);
    chk("exclusive", 32'(viol), 32'(0));
    if (valid) begin
      e = (sb.size() > 0) ? sb.pop_front() : 19'h7FFFF;
      chk("pair", 32'({instruction, Data_A, Data_B}), 32'(e));
    end
  end
  always @(posedge clk) if (rst) sb.delete();

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_burst(input int n, input logic [7:0] a0, input logic [7:0] b0,
                            input logic [15:0] rdy_mask, output int p);
    logic [7:0] a, b;
    a = a0; b = b0; p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) p = cyc;
      in_valid = 1'b1; in_a = a; in_b = b; in_instr = 3'(i);
      chk("in_ready", 32'(in_ready), 32'(rdy_mask[i]));
      if (rdy_mask[i]) sb.push_back({3'(i), a, b});
      a += 8'h44; b += 8'h44;
    end
    @(negedge clk);
    in_valid = 1'b0; in_a = '0; in_b = '0; in_instr = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, c0, ns, nrv, nto;
    logic [3:0] e;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_instr = '0;
    fin_en = 1'b1; fin_hold = 1; fin_max = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({start, valid, one_left, result_valid, timeout_err, busy}), 32'(0));
    chk("rst_data", 32'({Data_A, Data_B, instruction}), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;

    // T1: one operation, exact schedule relative to start at rel 1
    fin_max = 8'h5A;
    push_burst(4, 8'h12, 8'h34, 16'hFFFF, p);
    c0 = p + 4;
    for (int rel = 0; rel <= 18; rel++) begin
      goto(c0 + rel);
      e = {rel == 1, rel == 3 || rel == 5 || rel == 7 || rel == 10, rel == 9, rel == 14};
      chk("t1_sched", 32'({start, valid, one_left, result_valid}), 32'(e));
      chk("t1_busy", 32'(busy), 32'(rel >= 1 && rel <= 14));
      if (!valid) chk("t1_zero", 32'({Data_A, Data_B, instruction}), 32'(0));
    end
    chk("t1_result", 32'(result), 32'(8'h5A));
    chk("t1_rv_count", 32'(n_rv), 32'(1));

    // T3: three pairs never start; the fourth starts the cycle after count hits 4
    fin_max = 8'h77;
    ns = n_start;
    push_burst(3, 8'h01, 8'h80, 16'hFFFF, p);
    goto(p + 23);
    chk("t3_no_start", 32'(n_start - ns), 32'(0));
    chk("t3_idle", 32'(busy), 32'(0));
    push_burst(1, 8'hA0, 8'h0B, 16'hFFFF, p);
    c0 = p + 1;
    chk("t3_start_early", 32'(start), 32'(0));
    goto(c0 + 1);
    chk("t3_start", 32'(start), 32'(1));
    goto(c0 + 14);
    chk("t3_rv", 32'(result_valid), 32'(1));
    chk("t3_result", 32'(result), 32'(8'h77));
    goto(c0 + 16);

    // T2: ten back-to-back offers; the tenth meets a full FIFO during a SEND pop
    fin_hold = 4; fin_max = 8'hA1;
    ns = n_start;
    push_burst(10, 8'h20, 8'h02, 16'h01FF, p);
    chk("t2_first_start", 32'(n_start - ns), 32'(1));
    chk("t2_ready_after", 32'(in_ready), 32'(1));
    for (int rel = 10; rel <= 40; rel++) begin
      goto(p + rel);
      chk("t2_start", 32'(start), 32'(rel == 23));
      chk("t2_rv", 32'(result_valid), 32'(rel == 18 || rel == 36));
      if (rel == 18) chk("t2_res1", 32'(result), 32'(8'hA1));
      if (rel == 19) fin_max = 8'hB2;
    end
    chk("t2_res2", 32'(result), 32'(8'hB2));
    chk("t2_starts", 32'(n_start - ns), 32'(2));
    fin_hold = 1;

    // T4: one leftover pair plus three; finish never comes
    fin_en = 1'b0;
    nrv = n_rv; nto = n_to;
    push_burst(3, 8'h33, 8'h44, 16'hFFFF, p);
    goto(p + 268);
    chk("t4_pre_to", 32'({timeout_err, busy}), 32'(2'b01));
    goto(p + 269);
    chk("t4_to", 32'({timeout_err, busy}), 32'(2'b10));
    goto(p + 270);
    chk("t4_post_to", 32'({timeout_err, busy}), 32'(2'b00));
    chk("t4_to_count", 32'(n_to - nto), 32'(1));
    chk("t4_no_rv", 32'(n_rv - nrv), 32'(0));
    chk("t4_result", 32'(result), 32'(8'hB2));
    fin_en = 1'b1;

    // T5: reset during the second SEND with six pairs buffered
    push_burst(6, 8'h61, 8'h16, 16'hFFFF, p);
    goto(p + 9);
    chk("t5_send2", 32'(valid), 32'(1));
    rst = 1'b1;
    goto(p + 10);
    chk("t5_ctl", 32'({start, valid, one_left, result_valid, timeout_err, busy}), 32'(0));
    chk("t5_data", 32'({Data_A, Data_B, instruction}), 32'(0));
    chk("t5_result", 32'(result), 32'(0));
    chk("t5_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;
    ns = n_start; nrv = n_rv;
    // with the FIFO truly empty, three more pairs must not start an operation
    push_burst(3, 8'h05, 8'h50, 16'hFFFF, p);
    goto(p + 13);
    chk("t5_no_start", 32'(n_start - ns), 32'(0));
    chk("t5_no_rv", 32'(n_rv - nrv), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
